// File: rtl/regfile_onehot_wr_if.sv
// Register-file access bundle: two read ports, one one-hot write port,
// and the error/commit status returned by the register file.
//   master : writeback/decode side (drives selects, write data, qualifier)
//   slave  : register file (returns read data and status)
//   read1RegSel/read2RegSel  3-bit read indices
//   writeOneHot              one-hot write select from the 3-to-8 decoder
//   writeData/writeEn        writeback data and request qualifier
//   read1Data/read2Data      bypassed read data
//   err/errSticky            malformed-write flag (combinational / sticky)
//   writeCount               committed-write counter
interface regfile_onehot_wr_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2:0]            read1RegSel;
    logic [2:0]            read2RegSel;
    logic [7:0]            writeOneHot;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  writeEn;
    logic [DATA_WIDTH-1:0] read1Data;
    logic [DATA_WIDTH-1:0] read2Data;
    logic                  err;
    logic                  errSticky;
    logic [15:0]           writeCount;

    modport master (
        output read1RegSel, read2RegSel, writeOneHot, writeData, writeEn,
        input  read1Data, read2Data, err, errSticky, writeCount
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeOneHot, writeData, writeEn,
        output read1Data, read2Data, err, errSticky, writeCount
    );
endinterface

// File: rtl/regfile_onehot_wr.sv
// Eight-entry register file written through a one-hot select vector.
// Two combinational read ports with write-to-read bypass. Writes whose
// select is not exactly one-hot are rejected and flagged (err now,
// errSticky until reset). writeCount counts committed writes and wraps.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears registers and status)
//   bus    regfile_onehot_wr_if.slave (see interface header)
module regfile_onehot_wr #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8   // tied to the 8-bit one-hot select
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_onehot_wr_if.slave    bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  one_hot;
    logic                  wr_valid;
    logic [2:0]            wr_idx;
    logic                  errSticky_q;
    logic [15:0]           writeCount_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign one_hot  = (bus.writeOneHot != 8'h00) &&
                      ((bus.writeOneHot & (bus.writeOneHot - 8'h01)) == 8'h00);
    assign wr_valid = bus.writeEn && one_hot;
    assign bus.err  = bus.writeEn && !one_hot;

    // Index of the set bit; only meaningful when one_hot is true, and
    // every consumer is qualified by wr_valid.
    always_comb begin
        wr_idx = 3'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.writeOneHot[i]) wr_idx = i[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            errSticky_q  <= 1'b0;
            writeCount_q <= 16'h0000;
        end else begin
            if (wr_valid) begin
                regs[wr_idx] <= bus.writeData;
                writeCount_q <= writeCount_q + 16'd1;
            end
            if (bus.err) errSticky_q <= 1'b1;
        end
    end

    // Storage is already zero under reset; the rst_n gate keeps the bypass
    // path from leaking writeData onto the read ports while reset is held.
    assign bus.read1Data = !rst_n ? '0 :
                           (wr_valid && (wr_idx == bus.read1RegSel)) ? bus.writeData :
                           regs[bus.read1RegSel];
    assign bus.read2Data = !rst_n ? '0 :
                           (wr_valid && (wr_idx == bus.read2RegSel)) ? bus.writeData :
                           regs[bus.read2RegSel];

    assign bus.errSticky  = errSticky_q;
    assign bus.writeCount = writeCount_q;
endmodule
